// File: rtl/int_add_writeback.sv
// -----------------------------------------------------------------------------
// int_add_writeback
//
// Consumer end of the integer adder datapath. Every uop issued to the adder
// has its destination tag carried through a pipeline whose depth matches the
// adder latency. When the adder result lines up with the tag, the result is
// captured into an in-order FIFO. The FIFO head drives the shared register
// file write port, which an external arbiter grants.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   issue_valid   uop issued to the adder this cycle
//   issue_rd      destination register of the issued uop
//   issue_wen     issued uop writes rd
//   issue_ready   block can accept an issue this cycle (credit based)
//   add_value     adder result, valid ADDER_LAT cycles after issue
//   flush         squash all in-flight and buffered results
//   rf_grant      register file write port granted this cycle
//   rf_we         write request (head entry valid)
//   rf_waddr      head entry destination register
//   rf_wdata      head entry data
//   fifo_count    number of occupied FIFO entries
//   overflow_err  sticky: issue seen while issue_ready was low
// -----------------------------------------------------------------------------
module int_add_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDER_LAT  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [4:0]                  issue_rd,
    input  logic                        issue_wen,
    output logic                        issue_ready,
    input  logic [DATA_WIDTH-1:0]       add_value,
    input  logic                        flush,
    input  logic                        rf_grant,
    output logic                        rf_we,
    output logic [4:0]                  rf_waddr,
    output logic [DATA_WIDTH-1:0]       rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow_err
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    // Wide enough for FIFO occupancy plus up to four in-flight tags.
    localparam int SW   = CW + 3;
    localparam int LAST = ADDER_LAT - 1;

    // Pointer advance; FIFO_DEPTH is a power of two so the natural wrap of a
    // PW-bit counter is exactly modulo FIFO_DEPTH with no wasted entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return ptr + PW'(1'b1);
    endfunction

    // Number of valid in-flight tag stages.
    function automatic logic [SW-1:0] count_ones(input logic [ADDER_LAT-1:0] v);
        logic [SW-1:0] n;
        n = {SW{1'b0}};
        for (int i = 0; i < ADDER_LAT; i++) begin
            n = n + SW'(v[i]);
        end
        return n;
    endfunction

    // ---------------------------------------------------------------- state
    logic [ADDER_LAT-1:0]  tag_valid_q, tag_valid_d;
    logic [ADDER_LAT-1:0]  tag_wen_q,   tag_wen_d;
    logic [4:0]            tag_rd_q  [ADDER_LAT];
    logic [4:0]            tag_rd_d  [ADDER_LAT];

    logic [4:0]            mem_rd_q   [FIFO_DEPTH];
    logic [4:0]            mem_rd_d   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_d [FIFO_DEPTH];

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q,  count_d;

    logic                  rf_we_q,    rf_we_d;
    logic [4:0]            rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  issue_ready_q, issue_ready_d;
    logic                  overflow_q,    overflow_d;

    // ----------------------------------------------------------- datapath
    logic                  issue_acc_s;
    logic                  push_s;
    logic                  pop_s;
    logic [CW-1:0]         old_left_s;
    logic [SW-1:0]         credit_s;

    // Issue acceptance: a uop is tracked only when credit exists and no flush.
    always_comb begin
        issue_acc_s = issue_valid & issue_ready_q & ~flush;
    end

    // Tag pipeline shift; flush invalidates every stage at the edge.
    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_wen_d   = tag_wen_q;
        tag_rd_d    = tag_rd_q;
        for (int i = ADDER_LAT - 1; i > 0; i--) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_wen_d[i]   = tag_wen_q[i-1];
            tag_rd_d[i]    = tag_rd_q[i-1];
        end
        tag_valid_d[0] = issue_acc_s;
        tag_wen_d[0]   = issue_wen;
        tag_rd_d[0]    = issue_rd;
        if (flush) begin
            tag_valid_d = {ADDER_LAT{1'b0}};
        end else begin
            tag_valid_d = tag_valid_d;
        end
    end

    // Push/pop decisions. Results for rd=0 or wen=0 are dropped here. The
    // fullness guard never fires under correct credit use; it only keeps a
    // protocol violation from corrupting buffered entries.
    always_comb begin
        pop_s      = (count_q != {CW{1'b0}}) & rf_grant & ~flush;
        old_left_s = count_q - CW'(pop_s);
        push_s     = tag_valid_q[LAST] & tag_wen_q[LAST] &
                     (tag_rd_q[LAST] != 5'd0) & ~flush &
                     (old_left_s < CW'(FIFO_DEPTH));
    end

    // FIFO storage, pointers and occupancy next state.
    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        if (push_s) begin
            mem_rd_d[wr_ptr_q]   = tag_rd_q[LAST];
            mem_data_d[wr_ptr_q] = add_value;
        end else begin
            mem_rd_d   = mem_rd_q;
            mem_data_d = mem_data_q;
        end

        if (flush) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            count_d  = old_left_s + CW'(push_s);
        end
    end

    // Next head state for the write port. When no older entry survives this
    // cycle the new head is the entry being pushed, taken from the tag stage
    // and adder result directly; it only reaches rf_* through the flops.
    always_comb begin
        if (count_d == {CW{1'b0}}) begin
            rf_we_d    = 1'b0;
            rf_waddr_d = 5'd0;
            rf_wdata_d = {DATA_WIDTH{1'b0}};
        end else if (old_left_s == {CW{1'b0}}) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = tag_rd_q[LAST];
            rf_wdata_d = add_value;
        end else begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mem_rd_q[rd_ptr_d];
            rf_wdata_d = mem_data_q[rd_ptr_d];
        end
    end

    // Credit: buffered plus in-flight (including ones that will be dropped),
    // no credit for a pop in the same cycle. Evaluated on next state so the
    // registered issue_ready matches the registered occupancy it describes.
    always_comb begin
        credit_s      = SW'(count_d) + count_ones(tag_valid_d);
        issue_ready_d = (credit_s < SW'(FIFO_DEPTH));
        overflow_d    = overflow_q | (issue_valid & ~issue_ready_q);
    end

    // Tag pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_q <= {ADDER_LAT{1'b0}};
            tag_wen_q   <= {ADDER_LAT{1'b0}};
            for (int i = 0; i < ADDER_LAT; i++) begin
                tag_rd_q[i] <= 5'd0;
            end
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_wen_q   <= tag_wen_d;
            tag_rd_q    <= tag_rd_d;
        end
    end

    // FIFO storage and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_rd_q[i]   <= 5'd0;
                mem_data_q[i] <= {DATA_WIDTH{1'b0}};
            end
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Registered outputs: write port head, credit and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= 5'd0;
            rf_wdata_q    <= {DATA_WIDTH{1'b0}};
            issue_ready_q <= 1'b1;
            overflow_q    <= 1'b0;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            issue_ready_q <= issue_ready_d;
            overflow_q    <= overflow_d;
        end
    end

    assign issue_ready  = issue_ready_q;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign fifo_count   = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_int_add_writeback.sv
// -----------------------------------------------------------------------------
// tb_int_add_writeback
//
// Randomized bench for int_add_writeback. A queue-based reference model tracks
// accepted uops with the cycle their result is due, plus the ordered list of
// buffered results, and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_int_add_writeback;

    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          issue_wen;
    logic          issue_ready;
    logic [DW-1:0] add_value;
    logic          flush;
    logic          rf_grant;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [2:0]    fifo_count;
    logic          overflow_err;

    int_add_writeback #(
        .DATA_WIDTH (DW),
        .ADDER_LAT  (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_wen    (issue_wen),
        .issue_ready  (issue_ready),
        .add_value    (add_value),
        .flush        (flush),
        .rf_grant     (rf_grant),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fifo_count   (fifo_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    typedef struct packed {
        logic [4:0] rd;
        logic       wen;
        int         due;
    } infl_t;

    typedef struct packed {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } res_t;

    infl_t inflq[$];
    res_t  resq[$];
    bit    m_ovf;
    int    cyc;
    int    checks;
    int    errors;
    int    writes_seen;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        return (resq.size() + inflq.size()) < DEPTH;
    endfunction

    task automatic check_outputs();
        logic [4:0]    e_addr;
        logic [DW-1:0] e_data;
        e_addr = 5'd0;
        e_data = '0;
        if (resq.size() > 0) begin
            e_addr = resq[0].rd;
            e_data = resq[0].data;
        end
        check_eq("rf_we",        64'(rf_we),        64'(resq.size() > 0));
        check_eq("rf_waddr",     64'(rf_waddr),     64'(e_addr));
        check_eq("rf_wdata",     64'(rf_wdata),     64'(e_data));
        check_eq("fifo_count",   64'(fifo_count),   64'(resq.size()));
        check_eq("issue_ready",  64'(issue_ready),  64'(model_ready()));
        check_eq("overflow_err", 64'(overflow_err), 64'(m_ovf));
        if (rf_we === 1'b1 && rf_grant === 1'b1) writes_seen++;
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic model_step();
        bit    rdy;
        infl_t e;
        res_t  r;
        rdy = model_ready();
        if (issue_valid && !rdy) m_ovf = 1'b1;
        if (flush) begin
            resq.delete();
            inflq.delete();
        end else begin
            if (resq.size() > 0 && rf_grant) void'(resq.pop_front());
            if (inflq.size() > 0 && inflq[0].due == cyc) begin
                e = inflq.pop_front();
                if (e.wen && e.rd != 5'd0) begin
                    r.rd   = e.rd;
                    r.data = add_value;
                    resq.push_back(r);
                end
            end
            if (issue_valid && rdy) begin
                e.rd  = issue_rd;
                e.wen = issue_wen;
                e.due = cyc + LAT;
                inflq.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic drive_idle();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        issue_wen   = 1'b0;
        add_value   = '0;
        flush       = 1'b0;
        rf_grant    = 1'b0;
    endtask

    task automatic run_phase(input int ncyc, input int p_iss, input int p_gnt,
                             input int p_fl, input bit ignore_ready);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            check_outputs();
            add_value = $urandom;
            rf_grant  = (int'($urandom_range(0, 99)) < p_gnt);
            flush     = (int'($urandom_range(0, 99)) < p_fl);
            issue_valid = (int'($urandom_range(0, 99)) < p_iss) &&
                          (ignore_ready || model_ready());
            issue_rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue_wen = ($urandom_range(0, 5) != 0);
            model_step();
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        writes_seen = 0;
        cyc         = 0;
        m_ovf       = 1'b0;
        reset       = 1'b0;
        drive_idle();

        // Reset state.
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b1;
        model_step();

        // Free flowing, heavy backpressure, then mixed traffic with flushes.
        run_phase(150, 70, 90, 0, 1'b0);
        run_phase(150, 90, 10, 0, 1'b0);
        run_phase(300, 60, 50, 5, 1'b0);

        // Protocol violation: keep issuing with no grant until credit runs out.
        run_phase(12, 100, 0, 0, 1'b1);
        check_eq("ovf_sticky_set", 64'(m_ovf), 64'(1'b1));

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset = 1'b0;
        #1;
        resq.delete();
        inflq.delete();
        m_ovf = 1'b0;
        check_outputs();
        drive_idle();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        model_step();

        // Traffic after reset.
        run_phase(200, 60, 60, 3, 1'b0);

        @(negedge clk);
        check_outputs();
        check_eq("writes_happened", 64'(writes_seen > 50), 64'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
